// File: rtl/ncpu32k_cell_tdpram_sclk_pkg.sv
// Shared helpers for the single-clock true dual-port RAM cell.
// Lane count derivation lives here so port widths and write loops agree.
package ncpu32k_cell_tdpram_sclk_pkg;

   localparam int unsigned DefAw = 10;
   localparam int unsigned DefDw = 32;

   function automatic int unsigned byte_lanes(input int unsigned dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/ncpu32k_cell_tdpram_sclk.sv
// True dual-port single-clock RAM with per-byte write enables and registered
// read-first outputs; port B wins overlapping lanes on a same-address double write.
module ncpu32k_cell_tdpram_sclk
   import ncpu32k_cell_tdpram_sclk_pkg::*;
#(
   parameter int unsigned AW = DefAw,
   parameter int unsigned DW = DefDw
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en_a,
   input  logic [AW-1:0]       addr_a,
   input  logic [DW/8-1:0]     we_a,
   input  logic [DW-1:0]       din_a,
   output logic [DW-1:0]       dout_a,
   input  logic                en_b,
   input  logic [AW-1:0]       addr_b,
   input  logic [DW/8-1:0]     we_b,
   input  logic [DW-1:0]       din_b,
   output logic [DW-1:0]       dout_b
);

   localparam int Lanes = int'(byte_lanes(DW));

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] dout_a_q;
   logic [DW-1:0] dout_b_q;

   // Port B lanes are assigned after port A so B takes overlapping lanes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < Lanes; k++) begin
            if (en_a && we_a[k]) begin
               mem[addr_a][k*8 +: 8] <= din_a[k*8 +: 8];
            end
            if (en_b && we_b[k]) begin
               mem[addr_b][k*8 +: 8] <= din_b[k*8 +: 8];
            end
         end
      end
   end

   // Non-blocking reads sample the array before this edge's writes land.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_a_q <= '0;
         dout_b_q <= '0;
      end else begin
         if (en_a) begin
            dout_a_q <= mem[addr_a];
         end
         if (en_b) begin
            dout_b_q <= mem[addr_b];
         end
      end
   end

   assign dout_a = dout_a_q;
   assign dout_b = dout_b_q;

endmodule

// File: tb/tb_ncpu32k_cell_tdpram_sclk.sv
// Directed bench for the dual-port RAM cell: reset, byte masks, read-first,
// cross-port collision, enable hold and concurrent streaming.
module tb_ncpu32k_cell_tdpram_sclk;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          en_a;
   logic [AW-1:0] addr_a;
   logic [3:0]    we_a;
   logic [DW-1:0] din_a;
   logic [DW-1:0] dout_a;
   logic          en_b;
   logic [AW-1:0] addr_b;
   logic [3:0]    we_b;
   logic [DW-1:0] din_b;
   logic [DW-1:0] dout_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ncpu32k_cell_tdpram_sclk #(
      .AW(AW),
      .DW(DW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .en_a  (en_a),
      .addr_a(addr_a),
      .we_a  (we_a),
      .din_a (din_a),
      .dout_a(dout_a),
      .en_b  (en_b),
      .addr_b(addr_b),
      .we_b  (we_b),
      .din_b (din_b),
      .dout_b(dout_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en_a = 1'b0; we_a = '0; addr_a = '0; din_a = '0;
      en_b = 1'b0; we_b = '0; addr_b = '0; din_b = '0;
   endtask

   // One enabled cycle on port A only; dout_a is valid on return.
   task automatic cyc_a(input logic [AW-1:0] a, input logic [3:0] we, input logic [DW-1:0] d);
      en_a = 1'b1; addr_a = a; we_a = we; din_a = d;
      tick();
      en_a = 1'b0; we_a = '0;
   endtask

   task automatic cyc_b(input logic [AW-1:0] a, input logic [3:0] we, input logic [DW-1:0] d);
      en_b = 1'b1; addr_b = a; we_b = we; din_b = d;
      tick();
      en_b = 1'b0; we_b = '0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cyc_a(10'd5, 4'hF, 32'hCAFEF00D);
      rst = 1'b1;
      en_a = 1'b1; addr_a = 10'd5; we_a = 4'hF; din_a = 32'hFFFFFFFF;
      en_b = 1'b1; addr_b = 10'd5; we_b = 4'hF; din_b = 32'hFFFFFFFF;
      tick();
      tick();
      checks++;
      if (dout_a !== 32'h0) begin
         errors++;
         $display("FAIL reset_dout_a got %08h want %08h", dout_a, 32'h0);
      end
      checks++;
      if (dout_b !== 32'h0) begin
         errors++;
         $display("FAIL reset_dout_b got %08h want %08h", dout_b, 32'h0);
      end
      rst = 1'b0;
      idle();
      cyc_a(10'd5, 4'h0, 32'h0);
      checks++;
      if (dout_a !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL reset_write_ignored got %08h want %08h", dout_a, 32'hCAFEF00D);
      end
   endtask

   task automatic test_byte_mask();
      cyc_a(10'd3, 4'hF, 32'h11223344);
      cyc_a(10'd3, 4'b0101, 32'hAABBCCDD);
      cyc_a(10'd3, 4'h0, 32'h0);
      checks++;
      if (dout_a !== 32'h11BB33DD) begin
         errors++;
         $display("FAIL byte_mask got %08h want %08h", dout_a, 32'h11BB33DD);
      end
      // Port B sees the same merged word.
      cyc_b(10'd3, 4'h0, 32'h0);
      checks++;
      if (dout_b !== 32'h11BB33DD) begin
         errors++;
         $display("FAIL byte_mask_port_b got %08h want %08h", dout_b, 32'h11BB33DD);
      end
   endtask

   task automatic test_read_first();
      cyc_a(10'd7, 4'hF, 32'h0);
      cyc_a(10'd7, 4'hF, 32'hDEADBEEF);
      checks++;
      if (dout_a !== 32'h0) begin
         errors++;
         $display("FAIL read_first_old got %08h want %08h", dout_a, 32'h0);
      end
      cyc_a(10'd7, 4'h0, 32'h0);
      checks++;
      if (dout_a !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL read_first_new got %08h want %08h", dout_a, 32'hDEADBEEF);
      end
   endtask

   task automatic test_collision();
      cyc_a(10'd9, 4'hF, 32'hAAAAAAAA);
      en_a = 1'b1; addr_a = 10'd9; we_a = 4'hF;    din_a = 32'h01020304;
      en_b = 1'b1; addr_b = 10'd9; we_b = 4'b0011; din_b = 32'hF0F0F0F0;
      tick();
      idle();
      checks++;
      if (dout_b !== 32'hAAAAAAAA) begin
         errors++;
         $display("FAIL collision_old_b got %08h want %08h", dout_b, 32'hAAAAAAAA);
      end
      checks++;
      if (dout_a !== 32'hAAAAAAAA) begin
         errors++;
         $display("FAIL collision_old_a got %08h want %08h", dout_a, 32'hAAAAAAAA);
      end
      cyc_a(10'd9, 4'h0, 32'h0);
      checks++;
      if (dout_a !== 32'h0102F0F0) begin
         errors++;
         $display("FAIL collision_merge got %08h want %08h", dout_a, 32'h0102F0F0);
      end
   endtask

   task automatic test_enable_hold();
      for (int i = 0; i < 5; i++) begin
         cyc_a(10'(21 + i), 4'hF, 32'h5A000000 + 32'(i));
      end
      cyc_b(10'd20, 4'hF, 32'h12345678);
      cyc_b(10'd20, 4'h0, 32'h0);
      checks++;
      if (dout_b !== 32'h12345678) begin
         errors++;
         $display("FAIL hold_setup got %08h want %08h", dout_b, 32'h12345678);
      end
      en_b = 1'b0;
      for (int i = 0; i < 5; i++) begin
         addr_b = 10'(21 + i);
         we_b   = (i % 2 == 0) ? 4'hF : 4'h5;
         din_b  = 32'hFFFF0000 | 32'(i);
         tick();
         checks++;
         if (dout_b !== 32'h12345678) begin
            errors++;
            $display("FAIL hold_cycle%0d got %08h want %08h", i, dout_b, 32'h12345678);
         end
      end
      idle();
      for (int i = 0; i < 5; i++) begin
         cyc_a(10'(21 + i), 4'h0, 32'h0);
         checks++;
         if (dout_a !== (32'h5A000000 + 32'(i))) begin
            errors++;
            $display("FAIL hold_no_write%0d got %08h want %08h", i, dout_a,
                     32'h5A000000 + 32'(i));
         end
      end
   endtask

   task automatic test_independent_ports();
      for (int i = 0; i < 18; i++) begin
         en_a = (i < 16); addr_a = 10'(i); we_a = (i < 16) ? 4'hF : 4'h0; din_a = 32'(i * 3);
         en_b = (i >= 2); addr_b = 10'(i - 2); we_b = 4'h0; din_b = 32'h0;
         tick();
         if (i >= 2) begin
            checks++;
            if (dout_b !== 32'((i - 2) * 3)) begin
               errors++;
               $display("FAIL stream_addr%0d got %08h want %08h", i - 2, dout_b,
                        32'((i - 2) * 3));
            end
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_byte_mask();
      test_read_first();
      test_collision();
      test_enable_hold();
      test_independent_ports();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
